data_sram_responder: RTL

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/cpu_defs_pkg.sv | 27 ++
 rtl/sram_wen_gen.sv | 29 ++
 rtl/data_sram_responder.sv | 96 +++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU data-side definitions: access sizes, responder FSM states and
// the latched request payload.
package cpu_defs;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WEN_W  = DATA_W / 8;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } data_req_t;

endpackage

// File: rtl/sram_wen_gen.sv
// Byte-lane enables for a data access plus the misalignment flag that
// suppresses the write.
module sram_wen_gen
  import cpu_defs::*;
(
  input  logic [SIZE_W-1:0] size,
  input  logic [1:0]        addr_lo,
  output logic [WEN_W-1:0]  wen_c,
  output logic              misaligned_c
);

  always_comb begin
    wen_c        = '0;
    misaligned_c = 1'b0;
    case (size)
      SIZE_BYTE: wen_c = WEN_W'(4'b0001 << addr_lo);
      SIZE_HALF: begin
        wen_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned_c = addr_lo[0];
      end
      SIZE_WORD: begin
        wen_c        = 4'b1111;
        misaligned_c = (addr_lo != 2'b00);
      end
      default:   misaligned_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_sram_responder.sv
// Single-outstanding CPU data-port responder in front of a synchronous SRAM,
// with a programmable number of wait cycles before each RAM access.
module data_sram_responder
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [DATA_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              ram_en,
  output logic [WEN_W-1:0]  ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  data_req_t        req_q, req_d;
  logic [WEN_W-1:0] wen_c;
  logic             misaligned_c;
  logic             unused_addr_hi;

  // Address bits above the RAM word index are dropped silently.
  assign unused_addr_hi = ^req_q.addr[DATA_W-1:ADDR_W+2];

  sram_wen_gen u_wen_gen (
    .size         (req_q.size),
    .addr_lo      (req_q.addr[1:0]),
    .wen_c        (wen_c),
    .misaligned_c (misaligned_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Outputs are a pure decode of the flopped state so reset clears them at once.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    ram_en       = 1'b0;
    ram_wen      = '0;
    ram_addr     = '0;
    ram_wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        data_addr_ok = 1'b1;
        if (data_req) begin
          req_d   = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
          cnt_d   = CNT_W'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ram_en    = 1'b1;
          ram_addr  = req_q.addr[ADDR_W+1:2];
          ram_wdata = req_q.wdata;
          ram_wen   = (req_q.wr && !misaligned_c) ? wen_c : '0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        data_data_ok = 1'b1;
        data_rdata   = ram_rdata;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
